timer_multi: RTL and testbench

Parametrised multi-channel timer that replaces the single fixed-limit timer feeding the pipeline's interrupt logic. Provides NUM_CH independent up-counters with software-programmable limit, one-shot or periodic mode, per-channel interrupt enable and sticky pending flags cleared by write-1. Sits beside the data memory on the load/store bus; its `timer_interrupt` drives the CSR/interrupt controller.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_multi_if.sv | 12 +
 rtl/timer_channel.sv | 95 +++++++++
 rtl/timer_multi.sv | 75 +++++++
 tb/tb_timer_multi.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, control bit positions and mode/state types for timer_multi
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LIMIT  = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PERIODIC  = 1;
    localparam int CTRL_IE        = 2;
    localparam int STATUS_PENDING = 0;

    typedef enum logic {ONE_SHOT = 1'b0, PERIODIC = 1'b1} timer_mode_e;
    typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_e;

endpackage

// File: rtl/timer_multi_if.sv
// rtl/timer_multi_if.sv - register bus between the load/store unit and timer_multi
interface timer_multi_if #(
    parameter int WIDTH = 32
);
    logic             bus_wr;
    logic [4:0]       bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic [WIDTH-1:0] bus_rdata;

    modport master (output bus_wr, output bus_addr, output bus_wdata, input bus_rdata);
    modport slave  (input bus_wr, input bus_addr, input bus_wdata, output bus_rdata);
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: CTRL/LIMIT/COUNT/STATUS registers and match logic
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [1:0]       reg_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             pending,
    output logic             ie
);

    ch_state_e        state_q, state_d;
    timer_mode_e      mode_q, mode_d;
    logic             ie_q, ie_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic wr_ctrl, wr_limit, wr_count, wr_status;
    logic run, match;

    assign wr_ctrl   = wr_en && (reg_sel == REG_CTRL);
    assign wr_limit  = wr_en && (reg_sel == REG_LIMIT);
    assign wr_count  = wr_en && (reg_sel == REG_COUNT);
    assign wr_status = wr_en && (reg_sel == REG_STATUS);
    assign run       = (state_q == CH_RUN);
    assign match     = tick && run && (count_q == limit_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CH_IDLE;
            mode_q    <= ONE_SHOT;
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
            limit_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            ie_q      <= ie_d;
            pending_q <= pending_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
        end
    end

    // A CTRL write on the match edge overrides the one-shot self-disable.
    always_comb begin
        state_d = state_q;
        if (wr_ctrl) begin
            state_d = wdata[CTRL_EN] ? CH_RUN : CH_IDLE;
        end else if (match && (mode_q == ONE_SHOT)) begin
            state_d = CH_IDLE;
        end
    end

    always_comb begin
        mode_d  = wr_ctrl ? timer_mode_e'(wdata[CTRL_PERIODIC]) : mode_q;
        ie_d    = wr_ctrl ? wdata[CTRL_IE] : ie_q;
        limit_d = wr_limit ? wdata : limit_q;
        count_d = count_q;
        if (wr_count) begin
            count_d = wdata;
        end else if (tick && run) begin
            count_d = match ? '0 : count_q + WIDTH'(1);
        end
        // Hardware set beats a same-edge write-1-to-clear.
        pending_d = (pending_q && !(wr_status && wdata[STATUS_PENDING])) || match;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_EN]       = run;
                rdata[CTRL_PERIODIC] = (mode_q == PERIODIC);
                rdata[CTRL_IE]       = ie_q;
            end
            REG_LIMIT:  rdata = limit_q;
            REG_COUNT:  rdata = count_q;
            REG_STATUS: rdata[STATUS_PENDING] = pending_q;
            default:    rdata = '0;
        endcase
    end

    assign pending = pending_q;
    assign ie      = ie_q;

endmodule

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - multi-channel timer with shared prescaler and registered interrupt output
module timer_multi
    import timer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    timer_multi_if.slave        bus,
    output logic [NUM_CH-1:0]   irq_vec,
    output logic                timer_interrupt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic             timer_interrupt_q, timer_interrupt_d;
    logic [2:0]       ch_sel;
    logic [1:0]       reg_sel;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_pending, ch_ie;

    assign ch_sel  = bus.bus_addr[4:2];
    assign reg_sel = bus.bus_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q           <= '0;
            timer_interrupt_q <= 1'b0;
        end else begin
            presc_q           <= presc_d;
            timer_interrupt_q <= timer_interrupt_d;
        end
    end

    // Free-running divider; with PRESCALE=1 it stays at zero and ticks every cycle.
    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .wr_en   (bus.bus_wr && (ch_sel == 3'(i))),
            .reg_sel (reg_sel),
            .wdata   (bus.bus_wdata),
            .rdata   (ch_rdata[i]),
            .pending (ch_pending[i]),
            .ie      (ch_ie[i])
        );
    end

    // Unpopulated channel slots read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i)) begin
                rdata = ch_rdata[i];
            end
        end
    end

    assign bus.bus_rdata     = rdata;
    assign irq_vec           = ch_pending & ch_ie;
    assign timer_interrupt_d = |irq_vec;
    assign timer_interrupt   = timer_interrupt_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - self-checking bench for timer_multi with a behavioural register model
module tb_timer_multi;

    localparam int P0 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    timer_multi_if #(.WIDTH(32)) bus0 ();
    timer_multi_if #(.WIDTH(32)) bus1 ();

    logic [3:0] irq0, irq1;
    logic       ti0, ti1;

    timer_multi #(.NUM_CH(4), .WIDTH(32), .PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .irq_vec(irq0), .timer_interrupt(ti0));
    timer_multi #(.NUM_CH(4), .WIDTH(32), .PRESCALE(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .irq_vec(irq1), .timer_interrupt(ti1));

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of dut0 (PRESCALE=1)
    logic [31:0] m_count [4];
    logic [31:0] m_limit [4];
    bit          m_en [4];
    bit          m_per [4];
    bit          m_ie [4];
    bit          m_pend [4];
    bit          m_ti;
    int          m_cyc;

    function automatic logic [3:0] m_irq();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = m_pend[c] & m_ie[c];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int c;
        c = int'(a[4:2]);
        if (c >= 4) return 32'h0;
        case (a[1:0])
            2'd0:    return {29'h0, m_ie[c], m_per[c], m_en[c]};
            2'd1:    return m_limit[c];
            2'd2:    return m_count[c];
            default: return {31'h0, m_pend[c]};
        endcase
    endfunction

    task automatic model_step(input logic w, input logic [4:0] a, input logic [31:0] d);
        bit tick, nti, set;
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                m_count[c] = 0; m_limit[c] = 0;
                m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
            end
            m_ti = 0;
            m_cyc = 0;
            return;
        end
        tick = ((m_cyc % P0) == P0 - 1);
        m_cyc++;
        nti = |m_irq();
        for (int c = 0; c < 4; c++) begin
            set = 0;
            if (m_en[c] && tick) begin
                if (m_count[c] == m_limit[c]) begin
                    set = 1;
                    m_count[c] = 0;
                    if (!m_per[c]) m_en[c] = 0;
                end else begin
                    m_count[c] = m_count[c] + 1;
                end
            end
            if (w && int'(a[4:2]) == c) begin
                case (a[1:0])
                    2'd0: begin m_en[c] = d[0]; m_per[c] = d[1]; m_ie[c] = d[2]; end
                    2'd1: m_limit[c] = d;
                    2'd2: m_count[c] = d;
                    default: if (d[0]) m_pend[c] = 0;
                endcase
            end
            if (set) m_pend[c] = 1;
        end
        m_ti = nti;
    endtask

    task automatic cycle(input int sel, input logic w, input logic [4:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.bus_wr = w; bus0.bus_addr = a; bus0.bus_wdata = d;
        end else begin
            bus1.bus_wr = w; bus1.bus_addr = a; bus1.bus_wdata = d;
        end
        @(posedge clk);
        model_step((sel == 0) && w, a, d);
        @(negedge clk);
        bus0.bus_wr = 1'b0;
        bus1.bus_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic rd(input int sel, input logic [4:0] a, output logic [31:0] v);
        if (sel == 0) bus0.bus_addr = a; else bus1.bus_addr = a;
        #1;
        v = (sel == 0) ? bus0.bus_rdata : bus1.bus_rdata;
    endtask

    task automatic reset_all();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        cycle(0, 1'b1, 5'd0, 32'h7);
        cycle(0, 1'b1, 5'd2, 32'h5);
        cycle(1, 1'b1, 5'd8, 32'h3);
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a), v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, v); end
        end
        checks++;
        if (ti0 !== 1'b0 || ti1 !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b/%b exp=0/0", ti0, ti1); end
        checks++;
        if (irq0 !== 4'h0) begin errors++; $display("FAIL reset_irq_vec got=%b exp=0000", irq0); end
        rst = 1'b1;
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        reset_all();
        cycle(0, 1'b1, 5'd1, 32'd2);
        cycle(0, 1'b1, 5'd0, 32'd7);
        for (int k = 0; k < 4; k++) begin
            cycle(0, k > 0, 5'd3, 32'd1);
            rd(0, 5'd3, v);
            checks++;
            if (ti0 !== (k > 0) || v !== 32'd0) begin
                errors++; $display("FAIL periodic_clear k=%0d ti=%b pend=%0d exp ti=%0d pend=0", k, ti0, v, k > 0);
            end
            idle(1);
            rd(0, 5'd3, v);
            checks++;
            if (ti0 !== 1'b0 || v !== 32'd0) begin
                errors++; $display("FAIL periodic_gap k=%0d ti=%b pend=%0d exp 0/0", k, ti0, v);
            end
            idle(1);
            rd(0, 5'd3, v);
            checks++;
            if (v !== 32'd1 || irq0 !== 4'b0001 || ti0 !== 1'b0) begin
                errors++; $display("FAIL periodic_match k=%0d pend=%0d irq=%b ti=%b exp 1/0001/0", k, v, irq0, ti0);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v, c, s;
        reset_all();
        cycle(0, 1'b1, 5'd5, 32'd5);
        cycle(0, 1'b1, 5'd4, 32'd5);
        idle(5);
        rd(0, 5'd7, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL oneshot_early pend=%0d exp=0", v); end
        idle(1);
        rd(0, 5'd7, v); rd(0, 5'd4, c); rd(0, 5'd6, s);
        checks++;
        if (v !== 32'd1 || c !== 32'd4 || s !== 32'd0 || irq0 !== 4'b0010) begin
            errors++; $display("FAIL oneshot_match pend=%0d ctrl=%0d count=%0d irq=%b exp 1/4/0/0010", v, c, s, irq0);
        end
        idle(10);
        rd(0, 5'd4, c); rd(0, 5'd6, s);
        checks++;
        if (c !== 32'd4 || s !== 32'd0 || ti0 !== 1'b1) begin
            errors++; $display("FAIL oneshot_hold ctrl=%0d count=%0d ti=%b exp 4/0/1", c, s, ti0);
        end
        cycle(0, 1'b1, 5'd7, 32'd1);
        checks++;
        if (ti0 !== 1'b1) begin errors++; $display("FAIL oneshot_ti_lag got=%b exp=1", ti0); end
        idle(1);
        checks++;
        if (ti0 !== 1'b0) begin errors++; $display("FAIL oneshot_ti_fall got=%b exp=0", ti0); end
        idle(10);
        rd(0, 5'd7, v); rd(0, 5'd6, s);
        checks++;
        if (v !== 32'd0 || s !== 32'd0 || ti0 !== 1'b0) begin
            errors++; $display("FAIL oneshot_second pend=%0d count=%0d ti=%b exp 0/0/0", v, s, ti0);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        int n;
        reset_all();
        cycle(1, 1'b1, 5'd9, 32'd1);
        cycle(1, 1'b1, 5'd8, 32'd3);
        n = 0;
        rd(1, 5'd11, v);
        while (v[0] !== 1'b1 && n < 40) begin idle(1); n++; rd(1, 5'd11, v); end
        checks++;
        if (n >= 40) begin errors++; $display("FAIL prescale_first timeout cycles=%0d limit=40", n); end
        for (int r = 0; r < 2; r++) begin
            cycle(1, 1'b1, 5'd11, 32'd1);
            n = 1;
            rd(1, 5'd11, v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL prescale_clear r=%0d pend=%0d exp=0", r, v); end
            while (v[0] !== 1'b1 && n < 40) begin idle(1); n++; rd(1, 5'd11, v); end
            checks++;
            if (n !== 8) begin errors++; $display("FAIL prescale_period r=%0d got=%0d exp=8", r, n); end
        end
    endtask

    task automatic test_collision();
        logic [31:0] v, c;
        reset_all();
        cycle(0, 1'b1, 5'd1, 32'd2);
        cycle(0, 1'b1, 5'd0, 32'd7);
        idle(2);
        cycle(0, 1'b1, 5'd3, 32'd1);
        rd(0, 5'd3, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL collide_w1c pend=%0d exp=1", v); end
        cycle(0, 1'b1, 5'd3, 32'd1);
        rd(0, 5'd3, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL collide_w1c_plain pend=%0d exp=0", v); end
        idle(1);
        cycle(0, 1'b1, 5'd2, 32'h55);
        rd(0, 5'd2, c); rd(0, 5'd3, v);
        checks++;
        if (c !== 32'h55 || v !== 32'd1) begin
            errors++; $display("FAIL collide_count count=%h pend=%0d exp 55/1", c, v);
        end
        cycle(0, 1'b1, 5'd4, 32'd1);
        cycle(0, 1'b1, 5'd4, 32'd1);
        rd(0, 5'd4, c); rd(0, 5'd7, v);
        checks++;
        if (c !== 32'd1 || v !== 32'd1) begin
            errors++; $display("FAIL collide_ctrl ctrl=%0d pend=%0d exp 1/1", c, v);
        end
    endtask

    task automatic test_two_ch();
        logic [31:0] v0, v3;
        reset_all();
        cycle(0, 1'b1, 5'd1, 32'd3);
        cycle(0, 1'b1, 5'd13, 32'd3);
        cycle(0, 1'b1, 5'd12, 32'd7);
        cycle(0, 1'b1, 5'd0, 32'd3);
        cycle(0, 1'b1, 5'd2, 32'd2);
        rd(0, 5'd2, v0); rd(0, 5'd14, v3);
        checks++;
        if (v0 !== 32'd2 || v3 !== 32'd2) begin errors++; $display("FAIL two_align c0=%0d c3=%0d exp 2/2", v0, v3); end
        idle(2);
        rd(0, 5'd3, v0); rd(0, 5'd15, v3);
        checks++;
        if (v0 !== 32'd1 || v3 !== 32'd1 || irq0 !== 4'b1000 || ti0 !== 1'b0) begin
            errors++; $display("FAIL two_match p0=%0d p3=%0d irq=%b ti=%b exp 1/1/1000/0", v0, v3, irq0, ti0);
        end
        idle(1);
        checks++;
        if (ti0 !== 1'b1) begin errors++; $display("FAIL two_ti_rise got=%b exp=1", ti0); end
        cycle(0, 1'b1, 5'd15, 32'd1);
        rd(0, 5'd3, v0);
        checks++;
        if (irq0 !== 4'b0000 || ti0 !== 1'b1 || v0 !== 32'd1) begin
            errors++; $display("FAIL two_clear irq=%b ti=%b p0=%0d exp 0000/1/1", irq0, ti0, v0);
        end
        idle(1);
        checks++;
        if (ti0 !== 1'b0) begin errors++; $display("FAIL two_ti_fall got=%b exp=0", ti0); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] v;
        reset_all();
        for (int a = 16; a < 32; a++) begin
            cycle(0, 1'b1, 5'(a), $urandom | 32'h7);
            rd(0, 5'(a), v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL oor_read addr=%0d got=%h exp=0", a, v); end
        end
        for (int a = 0; a < 16; a++) begin
            rd(0, 5'(a), v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL oor_alias addr=%0d got=%h exp=0", a, v); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, d, e;
        logic [4:0]  a;
        logic        w;
        reset_all();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            d = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 6));
            cycle(0, w, a, d);
            checks++;
            if (irq0 !== m_irq() || ti0 !== m_ti) begin
                errors++; $display("FAIL rand_irq n=%0d irq=%b ti=%b exp %b/%b", n, irq0, ti0, m_irq(), m_ti);
            end
            for (int i = 0; i < 17; i++) begin
                a = (i < 16) ? 5'(i) : 5'($urandom_range(16, 31));
                rd(0, a, v);
                e = m_read(a);
                checks++;
                if (v !== e) begin errors++; $display("FAIL rand_read n=%0d addr=%0d got=%h exp=%h", n, a, v, e); end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        bus0.bus_wr = 1'b0; bus0.bus_addr = 5'd0; bus0.bus_wdata = 32'd0;
        bus1.bus_wr = 1'b0; bus1.bus_addr = 5'd0; bus1.bus_wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_oneshot();
        test_prescale();
        test_collision();
        test_two_ch();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
